// File: rtl/avalon_bus_arbiter.sv
// Two-host (instruction/data) round-robin arbiter onto one Avalon-MM agent, one outstanding transfer.
// Optional read-response timeout enabled by defining ARB_TIMEOUT_EN.
module avalon_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction host (read-only)
  input  logic [ADDR_W-1:0]     i_address,
  input  logic                  i_read,
  input  logic [DATA_W/8-1:0]   i_byteenable,
  output logic [DATA_W-1:0]     i_agent_to_host,
  output logic                  i_readdatavalid,
  output logic                  i_waitrequest,
  // data host
  input  logic [ADDR_W-1:0]     d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W/8-1:0]   d_byteenable,
  input  logic [DATA_W-1:0]     d_host_to_agent,
  output logic [DATA_W-1:0]     d_agent_to_host,
  output logic                  d_readdatavalid,
  output logic                  d_waitrequest,
  // shared agent
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [DATA_W-1:0]     m_host_to_agent,
  input  logic [DATA_W-1:0]     m_agent_to_host,
  input  logic                  m_readdatavalid,
  input  logic                  m_waitrequest,
  // debug: current FSM state encoding
  output logic [2:0]            dbg_state_o
);

  // Handshake: a request is accepted on a rising edge where the granted host holds
  // read/write high and m_waitrequest is low; read data is valid on readdatavalid only.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_I   = 3'd1,
    GRANT_D   = 3'd2,
    WAIT_RD_I = 3'd3,
    WAIT_RD_D = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;   // 1: data host received the most recent grant
  logic   i_req, d_req;
  logic   timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_wait;

  assign in_wait     = (state_q == WAIT_RD_I) || (state_q == WAIT_RD_D);
  // Fires on the TIMEOUT-th cycle spent in WAIT_RD without a response.
  assign timeout_hit = in_wait && !m_readdatavalid && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (in_wait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign i_agent_to_host = timeout_hit ? TIMEOUT_DATA : m_agent_to_host;
  assign d_agent_to_host = timeout_hit ? TIMEOUT_DATA : m_agent_to_host;
`else
  assign timeout_hit     = 1'b0;
  assign i_agent_to_host = m_agent_to_host;
  assign d_agent_to_host = m_agent_to_host;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d_d        = last_d_q;
    m_address       = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    m_byteenable    = '0;
    m_host_to_agent = '0;
    i_waitrequest   = 1'b1;
    d_waitrequest   = 1'b1;
    i_readdatavalid = 1'b0;
    d_readdatavalid = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || !last_d_q)) begin
          state_d  = GRANT_D;
          last_d_d = 1'b1;
        end else if (i_req) begin
          state_d  = GRANT_I;
          last_d_d = 1'b0;
        end
      end

      GRANT_I: begin
        m_address     = i_address;
        m_read        = i_read;
        m_byteenable  = i_byteenable;
        i_waitrequest = m_waitrequest;
        if (!i_read) begin
          state_d = IDLE;
        end else if (!m_waitrequest) begin
          if (m_readdatavalid) begin
            i_readdatavalid = 1'b1;
            state_d         = IDLE;
          end else begin
            state_d = WAIT_RD_I;
          end
        end
      end

      GRANT_D: begin
        // A simultaneous read+write forwards only the write.
        m_address       = d_address;
        m_write         = d_write;
        m_read          = d_read & ~d_write;
        m_byteenable    = d_byteenable;
        m_host_to_agent = d_host_to_agent;
        d_waitrequest   = m_waitrequest;
        if (!d_req) begin
          state_d = IDLE;
        end else if (!m_waitrequest) begin
          if (d_write) begin
            state_d = IDLE;
          end else if (m_readdatavalid) begin
            d_readdatavalid = 1'b1;
            state_d         = IDLE;
          end else begin
            state_d = WAIT_RD_D;
          end
        end
      end

      WAIT_RD_I: begin
        if (m_readdatavalid || timeout_hit) begin
          i_readdatavalid = 1'b1;
          state_d         = IDLE;
        end
      end

      WAIT_RD_D: begin
        if (m_readdatavalid || timeout_hit) begin
          d_readdatavalid = 1'b1;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter: read-data scoreboard plus per-step state/port checks.
module tb_avalon_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [2:0] S_IDLE = 3'd0, S_GI = 3'd1, S_GD = 3'd2, S_WI = 3'd3, S_WD = 3'd4;

  logic              clk, rst;
  logic [ADDR_W-1:0] i_address, d_address, m_address;
  logic              i_read, d_read, d_write;
  logic [3:0]        i_byteenable, d_byteenable, m_byteenable;
  logic [DATA_W-1:0] i_agent_to_host, d_agent_to_host, d_host_to_agent, m_host_to_agent;
  logic [DATA_W-1:0] m_agent_to_host;
  logic              i_readdatavalid, d_readdatavalid, i_waitrequest, d_waitrequest;
  logic              m_read, m_write, m_readdatavalid, m_waitrequest;
  logic [2:0]        dbg_state;

  // agent model: directed values, or a zero-wait responder when zw is set
  logic              zw, tb_rdv;
  logic [DATA_W-1:0] tb_data;
  assign m_readdatavalid = zw ? m_read : tb_rdv;
  assign m_agent_to_host = zw ? (m_address ^ 32'hA5A5_0000) : tb_data;

  int checks = 0;
  int errors = 0;
  int rd_accepts = 0;
  logic [DATA_W:0] exp_q[$];   // {host (1=data), read data}

  avalon_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_byteenable(i_byteenable),
    .i_agent_to_host(i_agent_to_host), .i_readdatavalid(i_readdatavalid),
    .i_waitrequest(i_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_byteenable(d_byteenable), .d_host_to_agent(d_host_to_agent),
    .d_agent_to_host(d_agent_to_host), .d_readdatavalid(d_readdatavalid),
    .d_waitrequest(d_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_host_to_agent(m_host_to_agent),
    .m_agent_to_host(m_agent_to_host), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: pops one expected response for every readdatavalid pulse
  task automatic sb_sample();
    logic [DATA_W:0] e;
    if (m_read === 1'b1 && m_waitrequest === 1'b0) rd_accepts++;
    if (i_readdatavalid === 1'b1 || d_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rdv", {30'd0, d_readdatavalid, i_readdatavalid}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_onehot", {31'd0, i_readdatavalid ^ d_readdatavalid}, 32'd1);
        chk("sb_host", {31'd0, d_readdatavalid}, {31'd0, e[DATA_W]});
        chk("sb_data", d_readdatavalid ? d_agent_to_host : i_agent_to_host, e[DATA_W-1:0]);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk({tag, "_i_wait"}, {31'd0, i_waitrequest}, 32'd1);
    chk({tag, "_d_wait"}, {31'd0, d_waitrequest}, 32'd1);
    chk({tag, "_m_rw"}, {30'd0, m_read, m_write}, 32'd0);
    chk({tag, "_m_addr"}, m_address, 32'd0);
    chk({tag, "_m_be"}, {28'd0, m_byteenable}, 32'd0);
    chk({tag, "_rdv"}, {30'd0, i_readdatavalid, d_readdatavalid}, 32'd0);
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
  endtask

  initial begin
    int acc0;
    logic [DATA_W-1:0] a;
    rst = 1'b1; zw = 1'b0; tb_rdv = 1'b0; tb_data = '0; m_waitrequest = 1'b0;
    i_address = '0; i_read = 1'b0; i_byteenable = '0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_byteenable = '0; d_host_to_agent = '0;
    do_reset();
    chk_reset_outputs("reset");

    // single instruction read, response two cycles after acceptance
    i_read = 1'b1; i_address = 32'h100; i_byteenable = 4'hF;
    settle();
    chk("t1_idle_i_wait", {31'd0, i_waitrequest}, 32'd1);
    step();
    chk("t1_state_gi", {29'd0, dbg_state}, {29'd0, S_GI});
    chk("t1_m_addr", m_address, 32'h100);
    chk("t1_m_read", {31'd0, m_read}, 32'd1);
    chk("t1_i_wait", {31'd0, i_waitrequest}, 32'd0);
    chk("t1_d_wait", {31'd0, d_waitrequest}, 32'd1);
    exp_q.push_back({1'b0, 32'h0050_0093});
    step();
    i_read = 1'b0;
    settle();
    chk("t1_state_wi", {29'd0, dbg_state}, {29'd0, S_WI});
    chk("t1_wait_m_read", {31'd0, m_read}, 32'd0);
    step();
    tb_rdv = 1'b1; tb_data = 32'h0050_0093;
    step();
    tb_rdv = 1'b0; tb_data = 32'h0;
    settle();
    chk("t1_back_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("t1_q_empty", exp_q.size(), 32'd0);

    // simultaneous requests after reset: data write wins, then instruction read
    do_reset();
    i_read = 1'b1; i_address = 32'h104; i_byteenable = 4'hF;
    d_write = 1'b1; d_address = 32'h2000; d_host_to_agent = 32'hCAFE_BABE; d_byteenable = 4'hF;
    step();
    chk("t2_state_gd", {29'd0, dbg_state}, {29'd0, S_GD});
    chk("t2_m_write", {30'd0, m_write, m_read}, 32'd2);
    chk("t2_m_addr", m_address, 32'h2000);
    chk("t2_m_wdata", m_host_to_agent, 32'hCAFE_BABE);
    chk("t2_m_be", {28'd0, m_byteenable}, 32'hF);
    chk("t2_i_wait", {31'd0, i_waitrequest}, 32'd1);
    chk("t2_d_wait", {31'd0, d_waitrequest}, 32'd0);
    step();
    d_write = 1'b0;
    settle();
    chk("t2_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("t2_i_wait_idle", {31'd0, i_waitrequest}, 32'd1);
    step();
    chk("t2_state_gi", {29'd0, dbg_state}, {29'd0, S_GI});
    chk("t2_i_addr", m_address, 32'h104);
    chk("t2_i_wait_grant", {31'd0, i_waitrequest}, 32'd0);
    exp_q.push_back({1'b0, 32'h1122_3344});
    step();
    i_read = 1'b0; tb_rdv = 1'b1; tb_data = 32'h1122_3344;
    step();
    tb_rdv = 1'b0;

    // continuous contention with a zero-wait agent: D,I,D,I,...
    zw = 1'b1;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_address = 32'h300 + 32'(k * 4);
      d_address = 32'h400 + 32'(k * 4);
      settle();
      chk("t3_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
      step();
      if (k % 2 == 0) begin
        chk("t3_grant_d", {29'd0, dbg_state}, {29'd0, S_GD});
        exp_q.push_back({1'b1, (32'h400 + 32'(k * 4)) ^ 32'hA5A5_0000});
      end else begin
        chk("t3_grant_i", {29'd0, dbg_state}, {29'd0, S_GI});
        exp_q.push_back({1'b0, (32'h300 + 32'(k * 4)) ^ 32'hA5A5_0000});
      end
      step();
    end
    i_read = 1'b0; d_read = 1'b0; zw = 1'b0;
    settle();
    chk("t3_q_empty", exp_q.size(), 32'd0);

    // agent backpressure for 3 cycles on a data read
    m_waitrequest = 1'b1;
    d_read = 1'b1; d_address = 32'h40; d_byteenable = 4'hF;
    step();
    acc0 = rd_accepts;
    for (int j = 0; j < 3; j++) begin
      chk("t4_d_wait", {31'd0, d_waitrequest}, 32'd1);
      chk("t4_m_addr", m_address, 32'h40);
      chk("t4_state", {29'd0, dbg_state}, {29'd0, S_GD});
      step();
    end
    m_waitrequest = 1'b0;
    settle();
    chk("t4_d_wait_rel", {31'd0, d_waitrequest}, 32'd0);
    exp_q.push_back({1'b1, 32'h0BAD_F00D});
    step();
    d_read = 1'b0;
    settle();
    chk("t4_state_wd", {29'd0, dbg_state}, {29'd0, S_WD});
    tb_rdv = 1'b1; tb_data = 32'h0BAD_F00D;
    step();
    tb_rdv = 1'b0;
    chk("t4_one_accept", 32'(rd_accepts - acc0), 32'd1);

    // data host withdraws before acceptance: no transfer
    m_waitrequest = 1'b1;
    d_read = 1'b1; d_address = 32'h44;
    step();
    d_read = 1'b0;
    step();
    m_waitrequest = 1'b0;
    settle();
    chk("t5_drop_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // reset while waiting on an instruction read; late response must be dropped
    i_read = 1'b1; i_address = 32'h500;
    step();
    step();
    i_read = 1'b0;
    settle();
    chk("t6_state_wi", {29'd0, dbg_state}, {29'd0, S_WI});
    rst = 1'b1;
    step();
    rst = 1'b0; tb_rdv = 1'b1; tb_data = 32'h7777_7777;
    settle();
    chk_reset_outputs("t6");
    step();
    tb_rdv = 1'b0;
    settle();
    chk("t6_still_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});

`ifdef ARB_TIMEOUT_EN
    // agent never answers: timeout response after 4 cycles in WAIT_RD
    d_read = 1'b1; d_address = 32'h60;
    step();
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    step();
    d_read = 1'b0;
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("t7_waiting", {29'd0, dbg_state}, {29'd0, S_WD});
      step();
    end
    settle();
    chk("t7_timeout_rdv", {31'd0, d_readdatavalid}, 32'd1);
    step();
    i_read = 1'b1; i_address = 32'h64;
    step();
    chk("t7_new_grant", {29'd0, dbg_state}, {29'd0, S_GI});
    i_read = 1'b0;
    step();
    step();
`endif

    a = 32'(exp_q.size());
    chk("final_q_empty", a, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
